gpi_debounce: RTL and testbench
===============================

// Module: gpi_debounce
// PURPOSE
//  Conditions raw board inputs (switches, buttons) before they reach the demo system's
//  general-purpose input port. Per bit: metastability synchroniser, then a counter-based
//  debouncer. Drives a clean level vector for gp_i and optional one-cycle edge pulses.
//  Instantiated in the FPGA top, between the board pins and ibex_demo_system.
// PARAMETERS
//  Width          5      number of independent input channels
//  SyncStages     2      synchroniser flop depth (>=2)
//  DebounceCycles 50000  consecutive cycles a new level must persist before acceptance (>=1)
//  ResetValue     '0     Width-bit level loaded into synchroniser and stable output on reset
// PORTS
//  clk_sys_i   in   1      system clock
//  rst_sys_i   in   1      synchronous reset, active-high
//  raw_i       in   Width  asynchronous raw pin levels
//  gp_o        out  Width  debounced stable level
//  rise_o      out  Width  1-cycle pulse on accepted 0->1 (needs GPI_DEBOUNCE_EDGE_EN)
//  fall_o      out  Width  1-cycle pulse on accepted 1->0 (needs GPI_DEBOUNCE_EDGE_EN)
//  changed_o   out  1      OR-reduction of rise_o|fall_o, registered with them
// BEHAVIOUR
//  - One clock (clk_sys_i); reset is synchronous and active-high (rst_sys_i).
//  - Reset: sync flops = ResetValue; gp_o = ResetValue; rise_o, fall_o, changed_o = 0;
//    all counters = 0; all channels in IDLE. Reset dominates every other event.
//  - Synchroniser: SyncStages flops per bit; sync_b is the last stage.
//  - Per-bit FSM, states IDLE / COUNT; counter width $clog2(DebounceCycles+1):
//    IDLE:  sync_b != gp_o[b]  -> COUNT, cnt <= 0.
//    COUNT: sync_b == gp_o[b]  -> IDLE, cnt <= 0 (glitch rejected, no pulse).
//           else if cnt == DebounceCycles-1 -> gp_o[b] <= sync_b, IDLE, cnt <= 0,
//             rise_o[b]/fall_o[b] high for exactly the next cycle.
//           else cnt <= cnt + 1.
//  - Counter never wraps; terminal compare fires before overflow.
//  - Latency: a persistent raw edge appears on gp_o SyncStages+DebounceCycles+1 cycles
//    after the first clock edge that samples it.
//  - Glitches shorter than DebounceCycles cycles at the sync_b stage never reach gp_o.
//  - A bounce inside COUNT restarts the count from 0 on the next opposite transition.
//  - Channels are fully independent; simultaneous changes give simultaneous pulses.
//  - Mid-operation reset: partial counts are discarded. No pulse in the cycle after
//    reset deasserts, even if raw_i differs from ResetValue; that difference is then
//    debounced normally.
// CONFIGURATION
//  GPI_DEBOUNCE_EDGE_EN defined: rise_o/fall_o/changed_o are registered pulses as above.
//  Not defined: the edge registers are not built. rise_o, fall_o and changed_o are
//  tied to 0. gp_o behaviour is identical in both builds.
// STRUCTURE
//  gpi_debounce_pkg: typedef enum logic {DbIdle, DbCount} db_state_e; helper function
//    for counter width.
//  Sub-module gpi_debounce_bit: synchroniser + FSM + counter for one channel.
//    Generated Width times; the top level holds only the pulse OR-reduction.
// TESTING (Width=5, SyncStages=2, DebounceCycles=4, ResetValue=5'b00000, EDGE_EN on)
//  1. Reset, raw_i=0 -> gp_o=0, no pulses; raw_i=5'b11111 during reset -> gp_o stays 0
//     until 7 cycles after release.
//  2. raw_i[0] 0->1 held -> gp_o[0]=1 exactly 7 cycles later; rise_o[0] and changed_o
//     high for 1 cycle.
//  3. raw_i[1] 3-cycle high glitch -> gp_o[1] stays 0; rise_o never asserts.
//  4. raw_i[2] high, 1-cycle drop at count 2, then high -> acceptance delayed; single
//     rise_o[2] pulse.
//  5. raw_i[4:3] 00->11 same cycle -> rise_o=5'b11000 in one cycle; then 1->0 gives
//     fall_o=5'b11000.
//  6. rst_sys_i pulsed mid-COUNT -> gp_o=0 and no pulse; re-run with macro undefined ->
//     rise_o/fall_o/changed_o constant 0, gp_o identical.

Source files
------------

// File: rtl/gpi_debounce_pkg.sv
// Shared types and helpers for the GPI debouncer: the per-channel state encoding
// and the counter-width calculation.
package gpi_debounce_pkg;

  typedef enum logic {
    DbIdle,
    DbCount
  } db_state_e;

  // The counter only needs to reach DebounceCycles-1, but keep at least one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One GPI channel: SyncStages-deep synchroniser followed by a counter debouncer.
// Edge pulse flops are built only when GPI_DEBOUNCE_EDGE_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// DbIdle  | synchronised input matches the accepted level, counter idle
// DbCount | input differs from accepted level, counting its persistence
module gpi_debounce_bit
  import gpi_debounce_pkg::*;
#(
  parameter int   SyncStages     = 2,
  parameter int   DebounceCycles = 50000,
  parameter logic ResetValue     = 1'b0
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CntW    = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] r_sync;
  logic                  w_sync_b;
  db_state_e             r_state;
  logic [CntW-1:0]       r_cnt;
  logic                  r_level;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_sync <= {SyncStages{ResetValue}};
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], raw_i};
    end
  end

  assign w_sync_b = r_sync[SyncStages-1];

`ifdef GPI_DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;
`endif

  // Terminal compare fires at DebounceCycles-1, so the counter never wraps.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_state <= DbIdle;
      r_cnt   <= '0;
      r_level <= ResetValue;
`ifdef GPI_DEBOUNCE_EDGE_EN
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`endif
    end else begin
`ifdef GPI_DEBOUNCE_EDGE_EN
      r_rise <= 1'b0;
      r_fall <= 1'b0;
`endif
      case (r_state)
        DbIdle: begin
          if (w_sync_b != r_level) begin
            r_state <= DbCount;
            r_cnt   <= '0;
          end
        end
        DbCount: begin
          if (w_sync_b == r_level) begin
            r_state <= DbIdle;
            r_cnt   <= '0;
          end else if (r_cnt == CntLast) begin
            r_level <= w_sync_b;
            r_state <= DbIdle;
            r_cnt   <= '0;
`ifdef GPI_DEBOUNCE_EDGE_EN
            r_rise  <= w_sync_b;
            r_fall  <= ~w_sync_b;
`endif
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
      endcase
    end
  end

  assign level_o = r_level;

`ifdef GPI_DEBOUNCE_EDGE_EN
  assign rise_o = r_rise;
  assign fall_o = r_fall;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/gpi_debounce.sv
// Board-input conditioner: Width independent synchroniser+debouncer channels.
// Edge pulses are real only when GPI_DEBOUNCE_EDGE_EN is defined, otherwise tied low.
module gpi_debounce #(
  parameter int               Width          = 5,
  parameter int               SyncStages     = 2,
  parameter int               DebounceCycles = 50000,
  parameter logic [Width-1:0] ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  logic [Width-1:0] w_level;
  logic [Width-1:0] w_rise;
  logic [Width-1:0] w_fall;

  for (genvar b = 0; b < Width; b++) begin : g_ch
    gpi_debounce_bit #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles),
      .ResetValue    (ResetValue[b])
    ) u_bit (
      .clk_sys_i(clk_sys_i),
      .rst_sys_i(rst_sys_i),
      .raw_i    (raw_i[b]),
      .level_o  (w_level[b]),
      .rise_o   (w_rise[b]),
      .fall_o   (w_fall[b])
    );
  end

  assign gp_o   = w_level;
  assign rise_o = w_rise;
  assign fall_o = w_fall;
  // Built from the registered pulses, so it lines up with them in the same cycle.
  assign changed_o = |(w_rise | w_fall);

endmodule

// File: tb/tb_gpi_debounce.sv
// Bench for gpi_debounce: expected output snapshots are queued when raw inputs change
// and compared on the cycle they are due; every other cycle must show no pulses.
module tb_gpi_debounce;

  localparam int W   = 5;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int LAT = SS + DC;  // edges after the sampling edge until gp_o updates

`ifdef GPI_DEBOUNCE_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '0;
  logic [W-1:0] gp;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  gpi_debounce #(
    .Width(W), .SyncStages(SS), .DebounceCycles(DC), .ResetValue('0)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .raw_i    (raw),
    .gp_o     (gp),
    .rise_o   (rise),
    .fall_o   (fall),
    .changed_o(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           at;
    logic [W-1:0] gp;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] sb_last = '0;
  logic [W-1:0] e_gp = '0;
  logic [W-1:0] e_rise = '0;
  logic [W-1:0] e_fall = '0;

  // Queue the output snapshot expected once gp_o takes value nxt at cycle 'at'.
  task automatic push(input int at, input logic [W-1:0] nxt);
    exp_t e;
    e.at   = at;
    e.gp   = nxt;
    e.rise = EDGE ? (nxt & ~sb_last) : '0;
    e.fall = EDGE ? (~nxt & sb_last) : '0;
    sb_last = nxt;
    sb.push_back(e);
  endtask

  // Advance one clock and load this cycle's expectation (no comparisons here).
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    e_rise = '0;
    e_fall = '0;
    if (rst) begin
      e_gp    = '0;
      sb_last = '0;
    end else if (sb.size() > 0 && sb[0].at == cyc) begin
      e      = sb.pop_front();
      e_gp   = e.gp;
      e_rise = e.rise;
      e_fall = e.fall;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 14; k++) begin
      if (k == 3) raw = '1;
      if (k == 5) begin
        rst = 1'b0;
        push(cyc + LAT + 1, '1);
      end
      step();
      if (gp !== e_gp) begin bad++; $display("FAIL reset gp cyc=%0d got=%b want=%b", cyc, gp, e_gp); end
      if (rise !== e_rise) begin bad++; $display("FAIL reset rise cyc=%0d got=%b want=%b", cyc, rise, e_rise); end
      if (fall !== e_fall) begin bad++; $display("FAIL reset fall cyc=%0d got=%b want=%b", cyc, fall, e_fall); end
      if (changed !== (|(e_rise | e_fall))) begin bad++; $display("FAIL reset changed cyc=%0d got=%b want=%b", cyc, changed, |(e_rise | e_fall)); end
      total += 4;
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL reset pending got=%0d want=0", sb.size()); sb.delete(); end
    raw = '0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      if (gp !== '0) begin bad++; $display("FAIL reset2 gp cyc=%0d got=%b want=0", cyc, gp); end
      total++;
    end
    rst = 1'b0;
  endtask

  task automatic test_single_rise();
    raw[0] = 1'b1;
    push(cyc + LAT + 1, 5'b00001);
    for (int k = 0; k < 10; k++) begin
      step();
      if (gp !== e_gp) begin bad++; $display("FAIL rise0 gp cyc=%0d got=%b want=%b", cyc, gp, e_gp); end
      if (rise !== e_rise) begin bad++; $display("FAIL rise0 rise cyc=%0d got=%b want=%b", cyc, rise, e_rise); end
      if (fall !== e_fall) begin bad++; $display("FAIL rise0 fall cyc=%0d got=%b want=%b", cyc, fall, e_fall); end
      if (changed !== (|(e_rise | e_fall))) begin bad++; $display("FAIL rise0 changed cyc=%0d got=%b want=%b", cyc, changed, |(e_rise | e_fall)); end
      total += 4;
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL rise0 pending got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 12; k++) begin
      raw[1] = (k < 3);
      step();
      if (gp !== e_gp) begin bad++; $display("FAIL glitch gp cyc=%0d got=%b want=%b", cyc, gp, e_gp); end
      if (rise !== e_rise) begin bad++; $display("FAIL glitch rise cyc=%0d got=%b want=%b", cyc, rise, e_rise); end
      if (fall !== e_fall) begin bad++; $display("FAIL glitch fall cyc=%0d got=%b want=%b", cyc, fall, e_fall); end
      if (changed !== (|(e_rise | e_fall))) begin bad++; $display("FAIL glitch changed cyc=%0d got=%b want=%b", cyc, changed, |(e_rise | e_fall)); end
      total += 4;
    end
  endtask

  // High for 3 samples, low for 1 (seen by the FSM while its count is 2), then high again:
  // acceptance is timed from the resumed high sample.
  task automatic test_bounce();
    for (int k = 0; k < 14; k++) begin
      if (k < 3) raw[2] = 1'b1;
      else if (k == 3) raw[2] = 1'b0;
      else if (k == 4) begin
        raw[2] = 1'b1;
        push(cyc + LAT + 1, 5'b00101);
      end
      step();
      if (gp !== e_gp) begin bad++; $display("FAIL bounce gp cyc=%0d got=%b want=%b", cyc, gp, e_gp); end
      if (rise !== e_rise) begin bad++; $display("FAIL bounce rise cyc=%0d got=%b want=%b", cyc, rise, e_rise); end
      if (fall !== e_fall) begin bad++; $display("FAIL bounce fall cyc=%0d got=%b want=%b", cyc, fall, e_fall); end
      if (changed !== (|(e_rise | e_fall))) begin bad++; $display("FAIL bounce changed cyc=%0d got=%b want=%b", cyc, changed, |(e_rise | e_fall)); end
      total += 4;
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL bounce pending got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 18; k++) begin
      if (k == 0) begin
        raw[4:3] = 2'b11;
        push(cyc + LAT + 1, 5'b11101);
      end
      if (k == 9) begin
        raw[4:3] = 2'b00;
        push(cyc + LAT + 1, 5'b00101);
      end
      step();
      if (gp !== e_gp) begin bad++; $display("FAIL simul gp cyc=%0d got=%b want=%b", cyc, gp, e_gp); end
      if (rise !== e_rise) begin bad++; $display("FAIL simul rise cyc=%0d got=%b want=%b", cyc, rise, e_rise); end
      if (fall !== e_fall) begin bad++; $display("FAIL simul fall cyc=%0d got=%b want=%b", cyc, fall, e_fall); end
      if (changed !== (|(e_rise | e_fall))) begin bad++; $display("FAIL simul changed cyc=%0d got=%b want=%b", cyc, changed, |(e_rise | e_fall)); end
      total += 4;
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL simul pending got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  // Reset lands while channel 1 is counting; afterwards the held raw levels are
  // debounced from scratch against the reset value.
  task automatic test_mid_reset();
    raw[1] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        push(cyc + LAT + 1, 5'b00111);
      end
      step();
      if (gp !== e_gp) begin bad++; $display("FAIL midrst gp cyc=%0d got=%b want=%b", cyc, gp, e_gp); end
      if (rise !== e_rise) begin bad++; $display("FAIL midrst rise cyc=%0d got=%b want=%b", cyc, rise, e_rise); end
      if (fall !== e_fall) begin bad++; $display("FAIL midrst fall cyc=%0d got=%b want=%b", cyc, fall, e_fall); end
      if (changed !== (|(e_rise | e_fall))) begin bad++; $display("FAIL midrst changed cyc=%0d got=%b want=%b", cyc, changed, |(e_rise | e_fall)); end
      total += 4;
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL midrst pending got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
